// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            fault;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetch entries with flush; flush may carry a
// simultaneous push, which then becomes the only entry.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);
  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, wr_idx;

  assign wr_idx = flush ? '0 : wr_ptr;
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= AW'(push);
      count  <= CW'(push);
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) mem[wr_idx] <= din;
  end

  // Issue credit upstream must make this unreachable.
  assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && !flush && count == CW'(DEPTH)));
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, credit-based ROM issue, redirect/fault
// handling, and a valid/ready buffered interface toward decode.
module fetch_unit #(
  parameter int              XLEN           = 32,
  parameter int              ROM_ADDR_WIDTH = 8,
  parameter logic [XLEN-1:0] RESET_VECTOR   = '0,
  parameter int              BUF_DEPTH      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      redirect_valid,
  input  logic [XLEN-1:0]           redirect_pc,
  output logic                      imem_en,
  output logic [ROM_ADDR_WIDTH-1:0] imem_addr,
  input  logic [XLEN-1:0]           imem_rdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_pc,
  output logic [XLEN-1:0]           out_instr,
  output logic                      out_fault
);
  import fetch_pkg::*;

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [XLEN-1:0] pc, inflight_pc;
  logic            inflight, fault_halt;
  logic [CW-1:0]   count;
  logic [CW:0]     occupancy;
  logic            pop, push, misaligned;
  fetch_entry_t    head, push_entry;

  assign out_valid  = rst & (count != '0);
  assign pop        = out_valid & out_ready;
  assign misaligned = redirect_valid & (redirect_pc[1:0] != 2'b00);

  // Entries held plus the one returning, minus what decode takes now.
  assign occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign imem_en   = rst & ~redirect_valid & ~fault_halt &
                     (occupancy < (CW+1)'(BUF_DEPTH));
  assign imem_addr = pc[ROM_ADDR_WIDTH+1:2];

  // A misaligned redirect injects a fault entry instead of returning data.
  always_comb begin
    push       = 1'b0;
    push_entry = '{pc: inflight_pc, instr: imem_rdata, fault: 1'b0};
    if (rst) begin
      if (redirect_valid) begin
        push       = misaligned;
        push_entry = '{pc: redirect_pc, instr: INSTR_NOP, fault: 1'b1};
      end else begin
        push = inflight;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc          <= RESET_VECTOR;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      fault_halt  <= 1'b0;
    end else if (redirect_valid) begin
      pc         <= redirect_pc;
      inflight   <= 1'b0;
      fault_halt <= misaligned;
    end else begin
      inflight <= imem_en;
      if (imem_en) begin
        pc          <= pc + XLEN'(4);
        inflight_pc <= pc;
      end
    end
  end

  fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (push_entry),
    .head  (head),
    .count (count)
  );

  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign out_fault = out_valid & head.fault;
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch front end for the RV32 single-cycle/next-gen core.
- Owns the program counter and drives a synchronous (1-cycle read latency) text-memory ROM.
- Handles branch/jump redirects and buffers fetched instructions with their PC in a small FIFO.
- Presents them to decode over a valid/ready handshake, so decode stalls no longer corrupt fetch.

Parameters:
XLEN, 32, width of PC and instruction word
ROM_ADDR_WIDTH, 8, word-address width of text ROM; imem_addr = pc[ROM_ADDR_WIDTH+1:2]
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be word aligned
BUF_DEPTH, 2, fetch FIFO entries (>=2, power of two)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
redirect_valid  in  1  taken branch/jump; sampled each posedge
redirect_pc  in  XLEN  redirect target
imem_en  out  1  ROM read enable this cycle
imem_addr  out  ROM_ADDR_WIDTH  ROM word address
imem_rdata  in  XLEN  ROM data, valid the cycle after imem_en
out_valid  out  1  instruction available to decode
out_ready  in  1  decode accepts
out_pc  out  XLEN  PC of head entry
out_instr  out  XLEN  instruction of head entry (NOP 32'h0000_0013 when out_fault)
out_fault  out  1  head entry is an instruction-address-misaligned fault

Behaviour:
Reset (rst==0 at posedge):
- pc<=RESET_VECTOR; FIFO emptied; inflight<=0; fault_halt<=0.
- Outputs while held in reset: out_valid=0, imem_en=0, out_fault=0.

Issue:
- pop = out_valid & out_ready.
- imem_en = rst & ~redirect_valid & ~fault_halt & (count + inflight - pop < BUF_DEPTH).
- imem_addr = pc[ROM_ADDR_WIDTH+1:2]. Addresses beyond ROM range wrap modulo 2^ROM_ADDR_WIDTH words.
- When imem_en is high: pc<=pc+4 at the posedge, inflight<=1, and the issued PC is saved as inflight_pc.
- XLEN overflow: pc wraps 32'hFFFF_FFFC -> 0.

Capture:
- When inflight==1, imem_rdata and inflight_pc are pushed into the FIFO at the posedge.
- Push and pop may occur in the same cycle; count is unchanged.
- Issue credit guarantees the FIFO never overflows. An overflow is an assertion failure.

Latency:
- Issue in cycle t -> out_valid with that entry in cycle t+2.
- Steady-state throughput is 1 instruction/cycle with out_ready held high and BUF_DEPTH>=2.

Output:
- FIFO head is registered. out_pc/out_instr/out_fault must be stable while out_valid & ~out_ready.

Redirect (redirect_valid at posedge):
- FIFO flushed, including an entry popped that cycle (the pop still counts as consumed).
- inflight<=0; ROM data returning next cycle is discarded.
- imem_en is forced to 0 in the redirect cycle.
- Aligned target: pc<=redirect_pc. New fetch issues at N+1; out_valid at N+3.
- Misaligned target (redirect_pc[1:0]!=0): fault_halt<=1, no further issue, and one fault entry {pc=redirect_pc, instr=NOP, fault=1} is written directly to the FIFO. It is visible at N+1 and stays at the head.
- Popping the fault entry leaves the FIFO empty and fetch halted. Only a later aligned redirect or reset clears fault_halt.

Simultaneous events:
- Redirect has priority over push and issue.
- Reset has priority over everything, including an in-flight read or a mid-flush.

Decomposition:
- fetch_pkg holds: XLEN, INSTR_NOP=32'h0000_0013, and the fetch_entry_t struct {pc, instr, fault}.
- Sub-module fetch_fifo (BUF_DEPTH entries of fetch_entry_t) provides push/pop/flush, count, registered head, and synchronous active-low reset.
- Issue credit, PC and redirect logic stay in fetch_unit.

Test Plan:
- Reset release, RESET_VECTOR=0x0, ROM[i]=0x100+i, out_ready=1 -> imem_addr 0,1,2... on consecutive cycles; out_valid from cycle 2; out_pc 0x0,0x4,0x8; out_instr 0x100,0x101,0x102; no bubbles.
- Backpressure: out_ready=0 for 5 cycles after the first entry -> imem_en drops once count+inflight=BUF_DEPTH; head holds pc 0x0; on release the sequence resumes with no loss or duplication.
- Redirect to 0x40 in cycle 6 while FIFO full and a read in flight -> imem_en=0 in cycle 6; imem_addr 0x10 in cycle 7; next out_pc is 0x40 in cycle 9; no stale PCs 0x18/0x1C appear.
- Misaligned redirect to 0x42 -> out_valid=1, out_fault=1, out_pc=0x42, out_instr=0x00000013 next cycle; after pop, out_valid=0 and imem_en=0; a later redirect to 0x80 resumes fetch.
- ROM_ADDR_WIDTH=4, pc running past 0x3C -> imem_addr wraps 15->0 while out_pc continues 0x40.
- rst asserted mid-stream with read in flight and FIFO non-empty -> next cycle out_valid=0; after release, fetch restarts at RESET_VECTOR with no residual entries.
